// File: rtl/rv0_pkg.sv
// Shared rv0 definitions: supported opcodes, OP/OP_IMM funct3 codes, issue slot
// states and the immediate-extraction helpers used by the issue stage.
package rv0_pkg;

    localparam int XLEN_SUPPORTED = 32;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } rv_opcode_e;

    typedef enum logic [2:0] {
        F3_ADD_SUB = 3'b000,
        F3_SLL     = 3'b001,
        F3_SLT     = 3'b010,
        F3_SLTU    = 3'b011,
        F3_XOR     = 3'b100,
        F3_SRL_SRA = 3'b101,
        F3_OR      = 3'b110,
        F3_AND     = 3'b111
    } alu_funct3_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // I-type immediate from insn[31:20], sign-extended.
    function automatic logic [31:0] imm_i(input logic [11:0] insn_31_20);
        return {{20{insn_31_20[11]}}, insn_31_20};
    endfunction

    // Shift amount from insn[24:20], zero-extended; insn[30] stays in the word.
    function automatic logic [31:0] shamt(input logic [4:0] insn_24_20);
        return {27'd0, insn_24_20};
    endfunction

endpackage

// File: rtl/rv0_regfile.sv
// Integer register file: x1..x31 storage, x0 hardwired to zero, two async read
// ports that bypass a same-cycle writeback, one synchronous write port.
module rv0_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [1:31];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && waddr_i != 5'd0) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if (raddr1_i != 5'd0) begin
            rdata1_o = (we_i && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i];
        end
        if (raddr2_i != 5'd0) begin
            rdata2_o = (we_i && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i];
        end
    end

endmodule

// File: rtl/rv0_issue.sv
// Operand-issue stage in front of the RV32I ALU: register read, operand select,
// busy scoreboard for RAW/WAW stalls, and a single registered issue slot.
module rv0_issue
    import rv0_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [31:0]     if_insn_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            alu_valid_o,
    input  logic            alu_ready_i,
    output logic [31:0]     alu_insn_o,
    output logic [XLEN-1:0] alu_addr_o,
    output logic [XLEN-1:0] alu_rdata1_o,
    output logic [XLEN-1:0] alu_rdata2_o,
    input  logic            wb_valid_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_wdata_i,
    input  logic            flush_i,
    output logic            illegal_o,
    output slot_state_e     dbg_state_o,
    output logic [31:0]     dbg_busy_o
);

    if (XLEN != XLEN_SUPPORTED) begin : g_xlen_check
        $error("rv0_issue: only XLEN=32 is supported");
    end

    // Handshakes: a transfer happens on a clock edge where valid && ready are
    // both high; valid never waits on ready, and the slot payload is held
    // unchanged while alu_valid_o && !alu_ready_i.

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      funct3;
    logic            is_legal, uses_rs1, uses_rs2;
    logic            hazard, accept, issue;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2, op1, op2;

    slot_state_e     state_q, state_d;
    logic [31:0]     busy_q, busy_d;
    logic [31:0]     slot_insn_q;
    logic [XLEN-1:0] slot_addr_q, slot_op1_q, slot_op2_q;
    logic            illegal_q;

    assign opcode = if_insn_i[6:0];
    assign rd     = if_insn_i[11:7];
    assign funct3 = if_insn_i[14:12];
    assign rs1    = if_insn_i[19:15];
    assign rs2    = if_insn_i[24:20];

    always_comb begin
        is_legal = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: is_legal = 1'b1;
            OPC_OP_IMM: begin
                is_legal = 1'b1;
                uses_rs1 = 1'b1;
            end
            OPC_OP: begin
                is_legal = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    rv0_regfile #(.XLEN(XLEN)) u_regfile (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2),
        .we_i     (wb_valid_i),
        .waddr_i  (wb_rd_i),
        .wdata_i  (wb_wdata_i)
    );

    // A register being written back this cycle is no longer a hazard.
    always_comb begin
        hazard = 1'b0;
        if (is_legal) begin
            if (uses_rs1 && busy_q[rs1] && !(wb_valid_i && wb_rd_i == rs1)) hazard = 1'b1;
            if (uses_rs2 && busy_q[rs2] && !(wb_valid_i && wb_rd_i == rs2)) hazard = 1'b1;
            if (busy_q[rd] && !(wb_valid_i && wb_rd_i == rd))               hazard = 1'b1;
        end
    end

    assign if_ready_o = !rst_i && !flush_i && !hazard &&
                        (state_q == SLOT_EMPTY || alu_ready_i);
    assign accept     = if_valid_i && if_ready_o;
    assign issue      = accept && is_legal;

    always_comb begin
        op1 = uses_rs1 ? rf_rdata1 : '0;
        op2 = '0;
        if (opcode == OPC_OP) begin
            op2 = rf_rdata2;
        end else if (opcode == OPC_OP_IMM) begin
            if (funct3 == F3_SLL || funct3 == F3_SRL_SRA) op2 = shamt(if_insn_i[24:20]);
            else                                          op2 = imm_i(if_insn_i[31:20]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= SLOT_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (issue) state_d = SLOT_FULL;
            SLOT_FULL:  if (alu_ready_i) state_d = issue ? SLOT_FULL : SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
        if (flush_i) state_d = SLOT_EMPTY;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_insn_q <= '0;
            slot_addr_q <= '0;
            slot_op1_q  <= '0;
            slot_op2_q  <= '0;
        end else if (issue) begin
            slot_insn_q <= if_insn_i;
            slot_addr_q <= if_addr_i;
            slot_op1_q  <= op1;
            slot_op2_q  <= op2;
        end
    end

    // Clear order matters: writeback and flush clear first, a new issue sets last.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i) busy_d[wb_rd_i] = 1'b0;
        if (flush_i && state_q == SLOT_FULL) busy_d[slot_insn_q[11:7]] = 1'b0;
        if (issue) busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            illegal_q <= accept && !is_legal;
        end
    end

    assign alu_valid_o  = (state_q == SLOT_FULL);
    assign alu_insn_o   = slot_insn_q;
    assign alu_addr_o   = slot_addr_q;
    assign alu_rdata1_o = slot_op1_q;
    assign alu_rdata2_o = slot_op2_q;
    assign illegal_o    = illegal_q;
    assign dbg_state_o  = state_q;
    assign dbg_busy_o   = busy_q;

endmodule

// File: tb/tb_rv0_issue.sv
// Bench for rv0_issue: directed scenarios plus randomized traffic, all checked
// every cycle against an architectural model of registers, busy bits and slot.
module tb_rv0_issue;
  import rv0_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic        if_ready_o;
  logic [31:0] if_insn = '0;
  logic [31:0] if_addr = '0;
  logic        alu_valid_o;
  logic        alu_ready = 1'b0;
  logic [31:0] alu_insn_o, alu_addr_o, alu_rdata1_o, alu_rdata2_o;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_wdata = '0;
  logic        flush = 1'b0;
  logic        illegal_o;
  slot_state_e dbg_state_o;
  logic [31:0] dbg_busy_o;

  always #5 clk = ~clk;

  rv0_issue #(.XLEN(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .if_valid_i   (if_valid),
    .if_ready_o   (if_ready_o),
    .if_insn_i    (if_insn),
    .if_addr_i    (if_addr),
    .alu_valid_o  (alu_valid_o),
    .alu_ready_i  (alu_ready),
    .alu_insn_o   (alu_insn_o),
    .alu_addr_o   (alu_addr_o),
    .alu_rdata1_o (alu_rdata1_o),
    .alu_rdata2_o (alu_rdata2_o),
    .wb_valid_i   (wb_valid),
    .wb_rd_i      (wb_rd),
    .wb_wdata_i   (wb_wdata),
    .flush_i      (flush),
    .illegal_o    (illegal_o),
    .dbg_state_o  (dbg_state_o),
    .dbg_busy_o   (dbg_busy_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // Architectural model
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_slot_v;
  logic [31:0] m_insn, m_addr, m_op1, m_op2;
  bit          m_illegal;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic bit f_legal(input logic [31:0] i);
    return i[6:0] == 7'h37 || i[6:0] == 7'h17 || i[6:0] == 7'h13 || i[6:0] == 7'h33;
  endfunction

  function automatic bit f_uses1(input logic [31:0] i);
    return i[6:0] == 7'h13 || i[6:0] == 7'h33;
  endfunction

  function automatic bit f_uses2(input logic [31:0] i);
    return i[6:0] == 7'h33;
  endfunction

  function automatic bit f_wb_hit(input logic [4:0] r);
    return wb_valid && wb_rd == r && r != 5'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (f_wb_hit(r)) return wb_wdata;
    return m_regs[r];
  endfunction

  function automatic bit m_ready();
    logic [31:0] i;
    bit haz;
    i = if_insn;
    haz = 1'b0;
    if (f_legal(i)) begin
      if (f_uses1(i) && m_busy[i[19:15]] && !f_wb_hit(i[19:15])) haz = 1'b1;
      if (f_uses2(i) && m_busy[i[24:20]] && !f_wb_hit(i[24:20])) haz = 1'b1;
      if (m_busy[i[11:7]] && !f_wb_hit(i[11:7])) haz = 1'b1;
    end
    if (rst) return 1'b0;
    return !flush && !haz && (!m_slot_v || alu_ready);
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int k = 0; k < 32; k++) v[k] = m_busy[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin
      m_regs[k] = '0;
      m_busy[k] = 1'b0;
    end
    m_slot_v = 1'b0;
    m_insn = '0;
    m_addr = '0;
    m_op1 = '0;
    m_op2 = '0;
    m_illegal = 1'b0;
    exp_q.delete();
  endtask

  // Compare every observable against the model, mid-cycle.
  task automatic cycle_check();
    bit          exp_ready;
    slot_state_e exp_state;
    logic [31:0] e;
    #3;
    exp_ready = m_ready();
    exp_state = m_slot_v ? SLOT_FULL : SLOT_EMPTY;
    n_cmp++;
    if (if_ready_o !== exp_ready) begin
      n_err++; $display("FAIL if_ready @%0t: got %b exp %b", $time, if_ready_o, exp_ready);
    end
    n_cmp++;
    if (alu_valid_o !== m_slot_v) begin
      n_err++; $display("FAIL alu_valid @%0t: got %b exp %b", $time, alu_valid_o, m_slot_v);
    end
    n_cmp++;
    if (dbg_state_o !== exp_state) begin
      n_err++; $display("FAIL slot_state @%0t: got %0d exp %0d", $time, dbg_state_o, exp_state);
    end
    n_cmp++;
    if (illegal_o !== m_illegal) begin
      n_err++; $display("FAIL illegal @%0t: got %b exp %b", $time, illegal_o, m_illegal);
    end
    n_cmp++;
    if (dbg_busy_o !== m_busy_vec()) begin
      n_err++; $display("FAIL busy @%0t: got %h exp %h", $time, dbg_busy_o, m_busy_vec());
    end
    if (m_slot_v) begin
      n_cmp++;
      if (alu_addr_o !== m_addr) begin
        n_err++; $display("FAIL alu_addr @%0t: got %h exp %h", $time, alu_addr_o, m_addr);
      end
      n_cmp++;
      if (alu_rdata1_o !== m_op1) begin
        n_err++; $display("FAIL alu_rdata1 @%0t: got %h exp %h", $time, alu_rdata1_o, m_op1);
      end
      n_cmp++;
      if (alu_rdata2_o !== m_op2) begin
        n_err++; $display("FAIL alu_rdata2 @%0t: got %h exp %h", $time, alu_rdata2_o, m_op2);
      end
      if (alu_ready && !flush && !rst) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL issue_order @%0t: got %h exp <none>", $time, alu_insn_o);
        end else begin
          e = exp_q.pop_front();
          if (alu_insn_o !== e) begin
            n_err++; $display("FAIL issue_order @%0t: got %h exp %h", $time, alu_insn_o, e);
          end
        end
      end
    end
  endtask

  // Advance one clock and update the model from the spec rules.
  task automatic cycle_adv();
    logic [31:0] i, a, o1, o2, wd, srd_insn;
    logic [4:0]  wr;
    bit          acc, lg, wv, fl, ar, r, sv;
    i = if_insn;
    a = if_addr;
    lg = f_legal(i);
    acc = if_valid && m_ready();
    o1 = f_uses1(i) ? m_read(i[19:15]) : 32'd0;
    o2 = 32'd0;
    if (i[6:0] == 7'h33) o2 = m_read(i[24:20]);
    else if (i[6:0] == 7'h13)
      o2 = (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? {27'd0, i[24:20]} : {{20{i[31]}}, i[31:20]};
    wv = wb_valid; wr = wb_rd; wd = wb_wdata;
    fl = flush; ar = alu_ready; r = rst; sv = m_slot_v; srd_insn = m_insn;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      if (wv && wr != 5'd0) begin
        m_regs[wr] = wd;
        m_busy[wr] = 1'b0;
      end
      if (fl && sv) begin
        m_busy[srd_insn[11:7]] = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (acc && lg && i[11:7] != 5'd0) m_busy[i[11:7]] = 1'b1;
      m_busy[0] = 1'b0;
      m_illegal = acc && !lg;
      if (fl) m_slot_v = 1'b0;
      else if (acc && lg) begin
        m_slot_v = 1'b1;
        m_insn = i; m_addr = a; m_op1 = o1; m_op2 = o2;
        exp_q.push_back(i);
      end else if (ar) m_slot_v = 1'b0;
    end
  endtask

  task automatic cycle();
    cycle_check();
    cycle_adv();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_valid = 1'b1;
    if_insn = enc_i(12'd1, 5'd0, 3'd0, 5'd2);
    alu_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (if_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_if_ready: got %b exp 0", if_ready_o); end
    n_cmp++;
    if (alu_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_alu_valid: got %b exp 0", alu_valid_o); end
    n_cmp++;
    if ({alu_insn_o, alu_addr_o, alu_rdata1_o, alu_rdata2_o} !== 128'd0) begin
      n_err++; $display("FAIL reset_alu_data: got %h %h %h %h exp 0", alu_insn_o, alu_addr_o, alu_rdata1_o, alu_rdata2_o);
    end
    n_cmp++;
    if (illegal_o !== 1'b0 || dbg_busy_o !== 32'd0) begin
      n_err++; $display("FAIL reset_flags: got illegal %b busy %h exp 0 0", illegal_o, dbg_busy_o);
    end
    model_reset();
    rst = 1'b0;
    if_valid = 1'b0;
    alu_ready = 1'b0;
  endtask

  task automatic test_addi();
    if_insn = enc_i(12'hFFB, 5'd0, 3'd0, 5'd1);
    if_addr = 32'h100;
    if_valid = 1'b1;
    alu_ready = 1'b0;
    cycle();
    if_valid = 1'b0;
    n_cmp++;
    if (alu_valid_o !== 1'b1 || alu_rdata1_o !== 32'd0) begin
      n_err++; $display("FAIL addi_issue: got valid %b op1 %h exp 1 0", alu_valid_o, alu_rdata1_o);
    end
    n_cmp++;
    if (alu_rdata2_o !== 32'hFFFF_FFFB) begin
      n_err++; $display("FAIL addi_op2: got %h exp fffffffb", alu_rdata2_o);
    end
    n_cmp++;
    if (dbg_busy_o[1] !== 1'b1) begin n_err++; $display("FAIL addi_busy1: got %b exp 1", dbg_busy_o[1]); end
  endtask

  task automatic test_raw_bypass();
    if_insn = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    if_addr = 32'h104;
    if_valid = 1'b1;
    alu_ready = 1'b1;
    repeat (2) begin
      cycle_check();
      n_cmp++;
      if (if_ready_o !== 1'b0) begin n_err++; $display("FAIL raw_stall: got %b exp 0", if_ready_o); end
      cycle_adv();
    end
    wb_valid = 1'b1; wb_rd = 5'd1; wb_wdata = 32'h1234;
    cycle_check();
    n_cmp++;
    if (if_ready_o !== 1'b1) begin n_err++; $display("FAIL raw_release: got %b exp 1", if_ready_o); end
    cycle_adv();
    wb_valid = 1'b0;
    n_cmp++;
    if (alu_valid_o !== 1'b1 || alu_rdata1_o !== 32'h1234) begin
      n_err++; $display("FAIL raw_bypass: got valid %b op1 %h exp 1 1234", alu_valid_o, alu_rdata1_o);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] add_w, next_w;
    add_w = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    next_w = enc_i(12'd7, 5'd0, 3'd0, 5'd6);
    alu_ready = 1'b0;
    if_insn = next_w;
    if_addr = 32'h108;
    if_valid = 1'b1;
    repeat (3) begin
      cycle_check();
      n_cmp++;
      if (if_ready_o !== 1'b0 || alu_insn_o !== add_w || alu_rdata1_o !== 32'h1234 || alu_addr_o !== 32'h104) begin
        n_err++; $display("FAIL backpressure_hold: got rdy %b insn %h op1 %h addr %h exp 0 %h 1234 104",
                          if_ready_o, alu_insn_o, alu_rdata1_o, alu_addr_o, add_w);
      end
      cycle_adv();
    end
    alu_ready = 1'b1;
    cycle_check();
    n_cmp++;
    if (if_ready_o !== 1'b1) begin n_err++; $display("FAIL backpressure_release: got %b exp 1", if_ready_o); end
    cycle_adv();
    if_valid = 1'b0;
    n_cmp++;
    if (alu_insn_o !== next_w) begin n_err++; $display("FAIL backpressure_next: got %h exp %h", alu_insn_o, next_w); end
  endtask

  task automatic test_srai();
    wb_valid = 1'b1; wb_rd = 5'd4; wb_wdata = 32'h8000_0000;
    cycle();
    wb_valid = 1'b0;
    if_insn = {7'h20, 5'd3, 5'd4, 3'd5, 5'd5, 7'h13};
    if_addr = 32'h10C;
    if_valid = 1'b1;
    cycle();
    if_valid = 1'b0;
    n_cmp++;
    if (alu_rdata1_o !== 32'h8000_0000 || alu_rdata2_o !== 32'd3) begin
      n_err++; $display("FAIL srai_ops: got %h %h exp 80000000 3", alu_rdata1_o, alu_rdata2_o);
    end
    n_cmp++;
    if (alu_insn_o[30] !== 1'b1) begin n_err++; $display("FAIL srai_bit30: got %b exp 1", alu_insn_o[30]); end
  endtask

  task automatic test_illegal();
    logic [31:0] busy_before;
    alu_ready = 1'b1;
    if_insn = 32'h0000_007F;
    if_valid = 1'b1;
    busy_before = m_busy_vec();
    cycle_check();
    n_cmp++;
    if (if_ready_o !== 1'b1) begin n_err++; $display("FAIL illegal_accept: got %b exp 1", if_ready_o); end
    cycle_adv();
    if_valid = 1'b0;
    n_cmp++;
    if (illegal_o !== 1'b1 || alu_valid_o !== 1'b0 || dbg_busy_o !== busy_before) begin
      n_err++; $display("FAIL illegal_pulse: got ill %b valid %b busy %h exp 1 0 %h",
                        illegal_o, alu_valid_o, dbg_busy_o, busy_before);
    end
    cycle();
    n_cmp++;
    if (illegal_o !== 1'b0) begin n_err++; $display("FAIL illegal_one_cycle: got %b exp 0", illegal_o); end
  endtask

  task automatic test_flush();
    alu_ready = 1'b0;
    if_insn = enc_i(12'd9, 5'd0, 3'd0, 5'd7);
    if_valid = 1'b1;
    cycle();
    if_valid = 1'b0;
    n_cmp++;
    if (dbg_busy_o[7] !== 1'b1) begin n_err++; $display("FAIL flush_pre_busy7: got %b exp 1", dbg_busy_o[7]); end
    flush = 1'b1;
    alu_ready = 1'b1;
    cycle();
    flush = 1'b0;
    n_cmp++;
    if (alu_valid_o !== 1'b0 || dbg_busy_o[7] !== 1'b0) begin
      n_err++; $display("FAIL flush_clear: got valid %b busy7 %b exp 0 0", alu_valid_o, dbg_busy_o[7]);
    end
    if_insn = enc_i(12'd1, 5'd7, 3'd0, 5'd8);
    if_valid = 1'b1;
    cycle_check();
    n_cmp++;
    if (if_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_follow: got %b exp 1", if_ready_o); end
    cycle_adv();
    if_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    alu_ready = 1'b0;
    if_insn = enc_i(12'd1, 5'd0, 3'd0, 5'd9);
    if_valid = 1'b1;
    cycle();
    if_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_cmp++;
    if (alu_valid_o !== 1'b0 || dbg_busy_o !== 32'd0) begin
      n_err++; $display("FAIL reset_mid: got valid %b busy %h exp 0 0", alu_valid_o, dbg_busy_o);
    end
    alu_ready = 1'b1;
  endtask

  task automatic test_random();
    int busy_list[$];
    int sel;
    logic [31:0] w;
    for (int c = 0; c < 800; c++) begin
      alu_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      if_valid = ($urandom_range(0, 3) != 0);
      if_addr = $urandom;
      w = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       w[6:0] = 7'h37;
        1:       w[6:0] = 7'h17;
        2, 3, 4, 5: w[6:0] = 7'h13;
        6, 7, 8: w[6:0] = 7'h33;
        default: w[6:0] = ($urandom_range(0, 1) == 0) ? 7'h03 : 7'h63;
      endcase
      w[11:7] = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      if_insn = w;
      busy_list.delete();
      for (int k = 1; k < 32; k++) if (m_busy[k]) busy_list.push_back(k);
      wb_valid = ($urandom_range(0, 9) < 4);
      if (busy_list.size() > 0 && $urandom_range(0, 9) < 7)
        wb_rd = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
      else
        wb_rd = 5'($urandom_range(0, 7));
      wb_wdata = $urandom;
      cycle();
    end
    if_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_addi();
    test_raw_bypass();
    test_backpressure();
    test_srai();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_random();
    cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
